led_status_sched: RTL

Priority scheduler for the microwave front-panel status LED. It owns the single LED output and shares it between four status requesters: door alarm, cook-finish event, cooking and setting. The block grants the LED to the highest-priority active requester and drives that requester's pattern (fast blink, counted slow blink, slow blink or solid on) from an internal tick divider. It sits between the main microwave FSM and the LED pin, and replaces ad-hoc per-mode LED muxing.

---
 rtl/led_status_if.sv | 24 ++
 rtl/led_status_sched.sv | 127 ++++++++++++
 2 files changed

// File: rtl/led_status_if.sv
// Status LED scheduler bus: requester levels/pulse in, LED drive and status out.
interface led_status_if;
    logic [3:0] i_req;
    logic       led;
    logic [2:0] o_mode;
    logic       o_busy;
    logic       o_done;

    modport master (
        output i_req,
        input  led,
        input  o_mode,
        input  o_busy,
        input  o_done
    );

    modport slave (
        input  i_req,
        output led,
        output o_mode,
        output o_busy,
        output o_done
    );
endinterface

// File: rtl/led_status_sched.sv
// Priority scheduler for the front-panel status LED (door > finish > cook > set).
// Define LED_STATUS_DONE_EN to build the o_done completion-pulse register.
module led_status_sched #(
    parameter int CLK_DIV       = 100,
    parameter int SLOW_HALF     = 50,
    parameter int FAST_HALF     = 10,
    parameter int FINISH_BLINKS = 3
) (
    input  logic        clk,
    input  logic        rst,
    led_status_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SOLID  = 3'd1,
        SLOW   = 3'd2,
        FAST   = 3'd3,
        FINISH = 3'd4
    } state_t;

    localparam int HMAX = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
    localparam int DW   = $clog2(CLK_DIV + 1);
    localparam int TW   = $clog2(HMAX + 1);
    localparam int BW   = $clog2(FINISH_BLINKS + 1);

    state_t        state, state_nxt;
    logic [DW-1:0] div, div_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt, half;
    logic [BW-1:0] bcnt, bcnt_nxt;
    logic          phase, phase_nxt;
    logic          pending, pend_nxt, pend_set;
    logic          led_q, led_nxt;
    logic          busy_q, busy_nxt;
    logic          tick, flip, fin_end, done_nxt;

    always_comb begin
        pend_set  = bus.i_req[2] && (state != FINISH);
        tick      = (div == DW'(CLK_DIV - 1));
        half      = (state == FAST) ? TW'(FAST_HALF - 1) : TW'(SLOW_HALF - 1);
        flip      = tick && (tcnt == half);
        // Sequence ends on the last tick of the final off phase.
        fin_end   = (state == FINISH) && flip && !phase &&
                    (bcnt == BW'(FINISH_BLINKS - 1));
        done_nxt  = fin_end && !bus.i_req[3];
        pend_nxt  = (pending || pend_set) && !done_nxt;

        state_nxt = IDLE;
        if (bus.i_req[3])      state_nxt = FAST;
        else if (pend_nxt)     state_nxt = FINISH;
        else if (bus.i_req[1]) state_nxt = SLOW;
        else if (bus.i_req[0]) state_nxt = SOLID;

        div_nxt   = div;
        tcnt_nxt  = tcnt;
        bcnt_nxt  = bcnt;
        phase_nxt = phase;
        if (state_nxt != state) begin
            div_nxt   = '0;
            tcnt_nxt  = '0;
            bcnt_nxt  = '0;
            phase_nxt = 1'b1;
        end else begin
            div_nxt = tick ? '0 : div + 1'b1;
            if (tick) tcnt_nxt = flip ? '0 : tcnt + 1'b1;
            if (flip) phase_nxt = !phase;
            // Off->on inside the finish sequence counts one blink.
            if (flip && !phase && (state == FINISH) &&
                (bcnt != BW'(FINISH_BLINKS)))
                bcnt_nxt = bcnt + 1'b1;
        end

        led_nxt = 1'b0;
        unique case (state_nxt)
            IDLE:   led_nxt = 1'b0;
            SOLID:  led_nxt = 1'b1;
            SLOW:   led_nxt = phase_nxt;
            FAST:   led_nxt = phase_nxt;
            FINISH: led_nxt = phase_nxt;
            default: led_nxt = 1'b0;
        endcase

        busy_nxt = (state_nxt == FINISH) || pend_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            div     <= '0;
            tcnt    <= '0;
            bcnt    <= '0;
            phase   <= 1'b1;
            pending <= 1'b0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            div     <= div_nxt;
            tcnt    <= tcnt_nxt;
            bcnt    <= bcnt_nxt;
            phase   <= phase_nxt;
            pending <= pend_nxt;
            led_q   <= led_nxt;
            busy_q  <= busy_nxt;
        end
    end

`ifdef LED_STATUS_DONE_EN
    logic done_q;

    always_ff @(posedge clk) begin
        if (rst) done_q <= 1'b0;
        else     done_q <= done_nxt;
    end

    assign bus.o_done = done_q;
`else
    logic unused_done;
    assign unused_done = done_nxt;
    assign bus.o_done  = 1'b0;
`endif

    assign bus.led    = led_q;
    assign bus.o_mode = state;
    assign bus.o_busy = busy_q;

endmodule
